// File: rtl/ice40_ws2812_strip_top.sv
// iCE40 top level: streams a 216-byte G,R,B frame buffer to a WS2812 strip, MSB first, with a
// latch gap between frames. Define STRIP_INVERT_EN when driving through an inverting level shifter.
module ice40_ws2812_strip_top #(
   parameter int NUM_LEDS  = 72,
   parameter int BIT_CYC   = 20,
   parameter int T0H_CYC   = 6,
   parameter int T1H_CYC   = 13,
   parameter int LATCH_CYC = 1000
) (
   input  logic CLK,
   input  logic RST_N,
   output logic PIN_1,
   output logic USBPU
);

   localparam int NUM_BYTES = NUM_LEDS * 3;

   localparam logic [1:0] S_LATCH = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_BIT   = 2'd2;

   localparam logic [4:0]  BIT_LAST   = 5'(BIT_CYC - 1);
   localparam logic [4:0]  T0H        = 5'(T0H_CYC);
   localparam logic [4:0]  T1H        = 5'(T1H_CYC);
   localparam logic [7:0]  BYTE_LAST  = 8'(NUM_BYTES - 1);
   localparam logic [10:0] LATCH_LAST = 11'(LATCH_CYC - 1);

`ifdef STRIP_INVERT_EN
   localparam logic IDLE_LVL = 1'b1;
`else
   localparam logic IDLE_LVL = 1'b0;
`endif

   // Frame buffer; filled externally, never cleared by reset.
   logic [7:0]  mem [0:NUM_BYTES-1];

   logic [1:0]  state_q,     state_d;
   logic [10:0] latch_cnt_q, latch_cnt_d;
   logic [7:0]  byte_idx_q,  byte_idx_d;
   logic [2:0]  bit_idx_q,   bit_idx_d;
   logic [4:0]  bit_cnt_q,   bit_cnt_d;
   logic [7:0]  shift_q;
   logic        pin_q,       pin_d;
   logic        load_s;
   logic        shift_en_s;
   logic        wave_s;
   logic [7:0]  rd_addr_s;

   // Next-state logic: latch gap, first-byte fetch, then contiguous bit slots with byte prefetch.
   always_comb begin
      state_d     = state_q;
      latch_cnt_d = latch_cnt_q;
      byte_idx_d  = byte_idx_q;
      bit_idx_d   = bit_idx_q;
      bit_cnt_d   = bit_cnt_q;
      load_s      = 1'b0;
      shift_en_s  = 1'b0;
      rd_addr_s   = byte_idx_q;
      case (state_q)
         S_LATCH: begin
            if (latch_cnt_q == LATCH_LAST) begin
               state_d     = S_FETCH;
               latch_cnt_d = 11'd0;
            end else begin
               latch_cnt_d = latch_cnt_q + 11'd1;
            end
         end
         S_FETCH: begin
            state_d   = S_BIT;
            load_s    = 1'b1;
            bit_cnt_d = 5'd0;
            bit_idx_d = 3'd7;
         end
         S_BIT: begin
            if (bit_cnt_q != BIT_LAST) begin
               bit_cnt_d = bit_cnt_q + 5'd1;
            end else begin
               bit_cnt_d = 5'd0;
               if (bit_idx_q != 3'd0) begin
                  bit_idx_d  = bit_idx_q - 3'd1;
                  shift_en_s = 1'b1;
               end else if (byte_idx_q == BYTE_LAST) begin
                  state_d     = S_LATCH;
                  latch_cnt_d = 11'd0;
                  byte_idx_d  = 8'd0;
                  bit_idx_d   = 3'd7;
               end else begin
                  // Next byte is read at the slot boundary so no idle cycle appears between bytes.
                  byte_idx_d = byte_idx_q + 8'd1;
                  rd_addr_s  = byte_idx_q + 8'd1;
                  bit_idx_d  = 3'd7;
                  load_s     = 1'b1;
               end
            end
         end
         default: begin
            state_d     = S_LATCH;
            latch_cnt_d = 11'd0;
            byte_idx_d  = 8'd0;
            bit_idx_d   = 3'd7;
            bit_cnt_d   = 5'd0;
         end
      endcase

      // Output level for the coming cycle; a new slot always starts high, whatever its bit.
      if (state_d != S_BIT) begin
         wave_s = 1'b0;
      end else if (bit_cnt_d == 5'd0) begin
         wave_s = 1'b1;
      end else if (shift_q[7]) begin
         wave_s = (bit_cnt_d < T1H);
      end else begin
         wave_s = (bit_cnt_d < T0H);
      end
      pin_d = wave_s ^ IDLE_LVL;
   end

   // Control state and registered strip output.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= S_LATCH;
         latch_cnt_q <= 11'd0;
         byte_idx_q  <= 8'd0;
         bit_idx_q   <= 3'd7;
         bit_cnt_q   <= 5'd0;
         pin_q       <= IDLE_LVL;
      end else begin
         state_q     <= state_d;
         latch_cnt_q <= latch_cnt_d;
         byte_idx_q  <= byte_idx_d;
         bit_idx_q   <= bit_idx_d;
         bit_cnt_q   <= bit_cnt_d;
         pin_q       <= pin_d;
      end
   end

   // Synchronous frame-memory read straight into the shift register; current bit is shift_q[7].
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         shift_q <= 8'h00;
      end else if (load_s) begin
         shift_q <= mem[rd_addr_s];
      end else if (shift_en_s) begin
         shift_q <= {shift_q[6:0], 1'b0};
      end else begin
         shift_q <= shift_q;
      end
   end

   assign PIN_1 = pin_q;
   assign USBPU = 1'b0;

endmodule

// File: tb/tb_ice40_ws2812_strip_top.sv
// Directed bench for ice40_ws2812_strip_top: measures every PIN_1 pulse (width, rise cycle)
// and compares against hand-computed WS2812 timing tables.
module tb_ice40_ws2812_strip_top;

   logic CLK   = 1'b0;
   logic RST_N = 1'b1;
   logic PIN_1;
   logic USBPU;

   ice40_ws2812_strip_top dut (
      .CLK  (CLK),
      .RST_N(RST_N),
      .PIN_1(PIN_1),
      .USBPU(USBPU)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Pulse monitor, sampled on the falling edge.
   int   widths[$];
   int   rises[$];
   logic prev_pin = 1'b0;
   int   cur_w    = 0;
   int   rst_bad  = 0;
   int   usb_bad  = 0;

   always @(negedge CLK) begin
      if (USBPU !== 1'b0) usb_bad++;
      if (!RST_N && PIN_1 !== 1'b0) rst_bad++;
      if (PIN_1 === 1'b1) begin
         if (prev_pin !== 1'b1) begin
            rises.push_back(cyc);
            cur_w = 1;
         end else begin
            cur_w++;
         end
      end else if (prev_pin === 1'b1) begin
         widths.push_back(cur_w);
      end
      prev_pin = PIN_1;
   end

   int nvec  = 0;
   int nfail = 0;

   typedef struct {
      string name;
      int    frame;
      int    idx;
      int    exp_w;
      int    exp_dt;
   } pvec_t;

   pvec_t vecs[$];
   int    base[4];

   function automatic int qw(input int i);
      if (i >= 0 && i < widths.size()) return widths[i];
      return -1;
   endfunction

   function automatic int qr(input int i);
      if (i >= 0 && i < rises.size()) return rises[i];
      return -100000;
   endfunction

   task automatic check(input string name, input int got, input int exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic wait_count(input bit use_rises, input int n, input int budget, input string what);
      int k;
      k = 0;
      while (((use_rises ? rises.size() : widths.size()) < n) && k < budget) begin
         @(negedge CLK);
         #1;
         k++;
      end
      if ((use_rises ? rises.size() : widths.size()) < n) begin
         nvec++;
         nfail++;
         $display("FAIL timeout %s: got %0d pulses, expected %0d", what,
                  use_rises ? rises.size() : widths.size(), n);
      end
   endtask

   task automatic add_vec(input int frame, input int idx, input int w, input int dt);
      pvec_t v;
      v.name   = $sformatf("f%0d_p%0d", frame, idx);
      v.frame  = frame;
      v.idx    = idx;
      v.exp_w  = w;
      v.exp_dt = dt;
      vecs.push_back(v);
   endtask

   initial begin
      int a5w[8];
      int rel;
      int bad;
      int b;

      a5w = '{13, 6, 13, 6, 6, 13, 6, 13};

      // Frame 1: A5 then 80 (boundary between bytes 0 and 1).
      for (int i = 0; i < 8; i++) add_vec(1, i, a5w[i], (i == 0) ? -1 : 20);
      add_vec(1, 8, 13, 20);
      add_vec(1, 9, 6, 20);
      // Frame 2 (after abort): A5 head, zero byte 214, FF byte 215.
      for (int i = 0; i < 8; i++) add_vec(2, i, a5w[i], -1);
      add_vec(2, 1719, 6, 20);
      for (int i = 1720; i < 1728; i++) add_vec(2, i, 13, 20);
      // Frame 3: wrap back to byte 0.
      for (int i = 0; i < 8; i++) add_vec(3, i, a5w[i], (i == 0) ? -1 : 20);

      for (int i = 0; i < 216; i++) dut.mem[i] = 8'h00;

      // Reset and latch with an all-zero buffer.
      #1 RST_N = 1'b0;
      repeat (20) @(negedge CLK);
      #1;
      check("pulses_during_reset", widths.size() + rises.size(), 0);
      rel     = cyc;
      RST_N   = 1'b1;
      base[0] = 0;

      wait_count(1'b1, 1, 1100, "first_rise");
      check("first_rise_after_release", qr(0) - rel, 1001);

      wait_count(1'b0, 1728, 36000, "zero_frame");
      dut.mem[0]   = 8'hA5;
      dut.mem[1]   = 8'h80;
      dut.mem[215] = 8'hFF;

      bad = 0;
      for (int i = 0; i < 1728; i++) begin
         if (qw(i) != 6) bad++;
         if (i > 0 && (qr(i) - qr(i - 1)) != 20) bad++;
      end
      check("zero_frame_bad_pulses", bad, 0);

      base[1] = 1728;
      wait_count(1'b1, base[1] + 1, 1100, "frame1_start");
      check("zero_frame_period", qr(base[1]) - qr(0), 35561);
      check("latch_gap_low", qr(1728) - qr(1727) - qw(1727), 1015);

      // Abort during the first bit of byte 100.
      wait_count(1'b1, base[1] + 801, 17000, "byte100");
      check("byte100_rise_offset", qr(base[1] + 800) - qr(base[1]), 16000);
      check("pin_high_before_abort", int'(PIN_1), 1);
      RST_N = 1'b0;
      #1;
      check("pin_low_on_abort", int'(PIN_1), 0);
      repeat (20) @(negedge CLK);
      #1;
      check("abort_queues_aligned", rises.size(), widths.size());
      base[2] = widths.size();
      rel     = cyc;
      RST_N   = 1'b1;

      wait_count(1'b1, base[2] + 1, 1100, "restart_rise");
      check("first_rise_after_abort", qr(base[2]) - rel, 1001);

      base[3] = base[2] + 1728;
      wait_count(1'b0, base[3] + 8, 37000, "wrap_frame");
      check("frame2_period", qr(base[3]) - qr(base[2]), 35561);
      check("last_byte_gap", qr(base[3]) - qr(base[3] - 1) - qw(base[3] - 1), 1008);

      foreach (vecs[k]) begin
         b = base[vecs[k].frame] + vecs[k].idx;
         check({vecs[k].name, "_width"}, qw(b), vecs[k].exp_w);
         if (vecs[k].exp_dt >= 0)
            check({vecs[k].name, "_period"}, qr(b) - qr(b - 1), vecs[k].exp_dt);
      end

      check("pin_high_in_reset_samples", rst_bad, 0);
      check("usbpu_nonzero_samples", usb_bad, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
